// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared master FSM states, response encoding and beat-count helper
`timescale 1ns/1ps
package axi4_lite_pkg;
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} master_state_t;
  localparam logic RESP_OK = 1'b1;
  function automatic int nb(input int sz, input int dsz);
    return 2 * sz / dsz;
  endfunction
endpackage

// File: rtl/axi4_lite_mult_master.sv
// axi4_lite_mult_master: writes {b,a} bytewise over AXI4-Lite, reads back the 2*SZ-bit product; ports: clk/rst, start/a/b -> res/busy/done/err, AW/W/B/AR/R channels
`timescale 1ns/1ps
module axi4_lite_mult_master
  import axi4_lite_pkg::*;
#(
  parameter int SZ  = 32,
  parameter int ASZ = 4,
  parameter int DSZ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SZ-1:0]    a,
  input  logic [SZ-1:0]    b,
  output logic [2*SZ-1:0]  res,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ASZ-1:0]   awaddr,
  output logic             awvalid,
  input  logic             awready,
  output logic [DSZ-1:0]   wdata,
  output logic             wvalid,
  input  logic             wready,
  input  logic             bresp,
  input  logic             bvalid,
  output logic             bready,
  output logic [ASZ-1:0]   araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [DSZ-1:0]   rdata,
  input  logic             rvalid,
  output logic             rready,
  input  logic             rresp
);
  localparam int NB = nb(SZ, DSZ);
  localparam int IW = $clog2(NB);
  master_state_t state, nxt;
  logic [IW-1:0] idx;
  logic [2*SZ-1:0] op;
  logic aw_ok, w_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs, last;
  assign awvalid = state == WADDR && !aw_ok;
  assign wvalid  = state == WADDR && !w_ok;
  assign bready  = state == WRESP;
  assign arvalid = state == RADDR;
  assign rready  = state == RDATA;
  assign busy    = state != IDLE && state != DONE;
  assign done    = state == DONE;
  assign awaddr  = ASZ'(idx);
  assign araddr  = ASZ'(idx);
  assign wdata   = op[idx*DSZ +: DSZ];
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign b_hs    = bvalid && bready;
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;
  assign last    = idx == IW'(NB - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? WADDR : IDLE;
      WADDR:   nxt = (aw_ok || aw_hs) && (w_ok || w_hs) ? WRESP : WADDR;
      WRESP:   nxt = b_hs ? (last ? RADDR : WADDR) : WRESP;
      RADDR:   nxt = ar_hs ? RDATA : RADDR;
      RDATA:   nxt = r_hs ? (last ? DONE : RADDR) : RDATA;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      op    <= '0;
      res   <= '0;
      err   <= 1'b0;
      aw_ok <= 1'b0;
      w_ok  <= 1'b0;
    end else begin
      state <= nxt;
      // AW and W complete independently; remember each until both are done
      aw_ok <= nxt == WADDR && (aw_ok || aw_hs);
      w_ok  <= nxt == WADDR && (w_ok || w_hs);
      if (state == IDLE && start) begin
        op  <= {b, a};
        err <= 1'b0;
        idx <= '0;
      end
      if (b_hs) begin
        err <= err | (bresp != RESP_OK);
        idx <= last ? '0 : idx + 1'b1;
      end
      if (r_hs) begin
        res[idx*DSZ +: DSZ] <= rdata;
        err <= err | (rresp != RESP_OK);
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_mult_master.sv
// tb_axi4_lite_mult_master: randomized scoreboard bench with a behavioural multiplier slave
`timescale 1ns/1ps
module tb_axi4_lite_mult_master;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] res;
  logic busy, done, err;
  logic [3:0] awaddr, araddr;
  logic [7:0] wdata, rdata;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bresp, bvalid, arready, rvalid, rresp;

  axi4_lite_mult_master dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .res(res), .busy(busy), .done(done), .err(err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0, mismatched = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          t0;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // test configuration, written only by the main process
  int wd_cfg = 0, bd_cfg = 0, st_cfg = 0, err_b = 99, err_r = 99;
  logic [63:0] cur_op = '0;

  // slave state, written only by the slave process
  logic [7:0] mem [8];
  logic [63:0] prod;
  logic aw_acc, b_pend, r_pend, aw_pend, w_pend, ar_pend;
  logic [3:0] aw_q, r_addr, aw_prev, ar_prev;
  logic [7:0] w_prev;
  int wdl, bdl, stall, w_cnt, b_cnt, ar_cnt, r_cnt;

  // Behavioural slave: outputs for the coming edge are set at the negedge, and the
  // handshakes that edge will perform are known because the master's outputs
  // depend only on its registers.
  initial begin
    {awready, wready, bresp, bvalid, arready, rvalid, rresp} = '0;
    rdata = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (rst || (!busy && !done)) begin
        {aw_acc, b_pend, r_pend, aw_pend, w_pend, ar_pend} = '0;
        wdl = 0; bdl = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        stall = st_cfg;
      end
      if (aw_pend) chk("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
      if (w_pend) chk("w_hold", {wvalid, wdata}, {1'b1, w_prev});
      if (ar_pend) chk("ar_hold", {arvalid, araddr}, {1'b1, ar_prev});
      if (awvalid || wvalid || arvalid || rready) chk("bready_excl", bready, 0);
      awready = 1'b1;
      wready  = aw_acc && wdl == 0;
      bvalid  = b_pend && bdl == 0;
      bresp   = b_cnt != err_b;
      arready = stall == 0;
      rvalid  = r_pend;
      prod    = 64'({mem[7], mem[6], mem[5], mem[4]}) * 64'({mem[3], mem[2], mem[1], mem[0]});
      rdata   = prod[int'(r_addr)*8 +: 8];
      rresp   = r_cnt != err_r;
      if (rvalid && rready) begin r_pend = 1'b0; r_cnt++; end
      if (bvalid && bready) begin b_pend = 1'b0; b_cnt++; end
      if (wvalid && wready) begin
        chk("wdata", wdata, cur_op[int'(aw_q)*8 +: 8]);
        mem[aw_q] = wdata; aw_acc = 1'b0; b_pend = 1'b1; bdl = bd_cfg; w_cnt++;
      end else if (b_pend && bdl > 0) bdl--;
      if (awvalid && awready) begin
        chk("aw_addr", awaddr, w_cnt);
        aw_acc = 1'b1; wdl = wd_cfg; aw_q = awaddr;
      end else if (aw_acc && wdl > 0) wdl--;
      if (arvalid && !arready) stall--;
      if (arvalid && arready) begin
        chk("ar_addr", araddr, ar_cnt);
        ar_cnt++; r_pend = 1'b1; r_addr = araddr;
      end
      aw_pend = awvalid && !awready; aw_prev = awaddr;
      w_pend  = wvalid && !wready;   w_prev  = wdata;
      ar_pend = arvalid && !arready; ar_prev = araddr;
    end
  end

  // Monitor: every done pulse is matched against the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL spurious_done: done=1 with no transaction outstanding (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("res", res, e.res);
          chk("err", err, e.err);
          chk("busy_at_done", busy, 0);
          chk("n_writes", w_cnt, 8);
          chk("n_bresp", b_cnt, 8);
          chk("n_reads", r_cnt, 8);
          chk("latency", cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_res"}, res, 0);       chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);     chk({tag, "_err"}, err, 0);
    chk({tag, "_awaddr"}, awaddr, 0); chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wdata"}, wdata, 0);   chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0); chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_arvalid"}, arvalid, 0); chk({tag, "_rready"}, rready, 0);
  endtask

  task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input int wd, input int bd,
                       input int st, input int eb, input int er);
    exp_t e;
    wd_cfg = wd; bd_cfg = bd; st_cfg = st; err_b = eb; err_r = er;
    @(negedge clk);
    @(negedge clk);
    a = ai; b = bi; cur_op = {bi, ai};
    e.res = 64'(ai) * 64'(bi);
    e.err = eb < 8 || er < 8;
    e.t0  = cyc;
    e.lat = 1 + 8 * (3 + wd + bd) + 8 * 2 + st;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() > 0 && n < 3000) begin @(negedge clk); n++; end
    if (sb.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL done_timeout: no done within 3000 cycles, %0d outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] ai, input logic [31:0] bi, input int wd, input int bd,
                     input int st, input int eb, input int er);
    issue(ai, bi, wd, bd, st, eb, er);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_zero("rst_init");
    rst = 1'b0;
    @(negedge clk);
    run(32'h12345678, 32'h00000010, 0, 0, 0, 99, 99);
    run(32'hdeadbeef, 32'h0badf00d, 3, 2, 0, 99, 99);
    run(32'hffffffff, 32'hffffffff, 0, 0, 10, 99, 99);
    run($urandom, $urandom, 0, 0, 0, 2, 5);
    run($urandom, $urandom, 0, 0, 0, 99, 99);
    issue($urandom, $urandom, 1, 1, 0, 99, 99);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue($urandom, $urandom, 0, 0, 0, 99, 99);
    n = 0;
    while (!(arvalid && araddr == 4'd3) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      compared++; mismatched++;
      $display("FAIL raddr3_timeout: read beat 3 never reached");
    end
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run(32'h00c0ffee, 32'h00001234, 0, 0, 0, 99, 99);
    repeat (10)
      run($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 12),
          $urandom_range(0, 31), $urandom_range(0, 31));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axi4_lite_mult_master.md
Name: axi4_lite_mult_master

Overview:
- AXI4-Lite initiator that drives the multiplier slave wrapper over its 1-bit-response AXI4-Lite interface.
- On a user start pulse it:
  - writes operand a as bytes to addresses 0..NB/2-1 and operand b to NB/2..NB-1;
  - reads all NB result bytes back from addresses 0..NB-1;
  - presents the 2*SZ-bit product with a done pulse.
- Sits between a test/host controller and the slave wrapper.

Parameters:
- SZ, 32, operand width in bits.
- ASZ, 4, AXI address width.
- DSZ, 8, AXI data width (one byte-lane register per beat).
- Derived: NB = 2*SZ/DSZ (8 at defaults), beat count for both the write and read phases.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin transaction; sampled only in IDLE.
- a  input  SZ  operand a.
- b  input  SZ  operand b.
- res  output  2*SZ  product; NB read bytes, byte i = address i.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  some bresp/rresp was 0 in the last transaction.
- awaddr  output  ASZ  write address.
- awvalid  output  1  write address valid.
- awready  input  1  write address ready.
- wdata  output  DSZ  write data.
- wvalid  output  1  write data valid.
- wready  input  1  write data ready.
- bresp  input  1  write response, 1 = ok.
- bvalid  input  1  write response valid.
- bready  output  1  write response ready.
- araddr  output  ASZ  read address.
- arvalid  output  1  read address valid.
- arready  input  1  read address ready.
- rdata  input  DSZ  read data.
- rvalid  input  1  read data valid.
- rready  output  1  read data ready.
- rresp  input  1  read response, 1 = ok.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0: res, busy, done, err, awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready.
  - State IDLE; beat index idx = 0.
  - Reset mid-transaction abandons it immediately; no completion pulse follows.
- All handshakes complete on a rising edge with valid & ready high.
- Master never drops a valid before its handshake, and never changes addr/data while valid is high.
- IDLE:
  - busy=0.
  - start=1: latch {b,a} into an internal 2*SZ operand register, clear err, idx=0, busy=1, go to WADDR.
  - res is not cleared on start; it is overwritten byte by byte as reads land.
- WADDR:
  - awvalid=1, awaddr=idx.
  - wvalid=1, wdata = operand byte idx.
  - AW and W each deassert independently on their own handshake. The slave raises wready only after AW is accepted; the master tolerates either order.
  - When both have completed (same or different cycles), go to WRESP.
- WRESP:
  - bready=1.
  - On the B handshake: err |= ~bresp.
  - If idx==NB-1: idx=0, go to RADDR; else idx++, go to WADDR.
- RADDR:
  - arvalid=1, araddr=idx.
  - Held until arready; the slave withholds arready until the multiplier is ready, with no bound.
  - On handshake go to RDATA.
- RDATA:
  - rready=1.
  - On the R handshake: res byte idx = rdata, err |= ~rresp.
  - If idx==NB-1 go to DONE; else idx++, go to RADDR.
- DONE:
  - done=1 for exactly one cycle, busy=0 in that cycle, go to IDLE.
  - res and err are held until the next start.
- start while busy is ignored, with no queuing.
- A response of 0 does not abort; all NB beats still run.
- Minimum latency against a zero-wait slave of this family: 3 cycles per write beat and 2 cycles per read beat. At defaults, start to done is 41 cycles (1 + 24 + 16).
- Index counter width is $clog2(NB). It never wraps past NB-1; it is reset to 0 between phases.

Decomposition:
- Package axi4_lite_pkg:
  - typedef enum master_state_t {IDLE, WADDR, WRESP, RADDR, RDATA, DONE};
  - localparam-style function nb(SZ, DSZ);
  - RESP_OK = 1'b1.
- No sub-module. A single FSM plus datapath; byte select by indexed part-select.

Test Plan:
- Basic: a=32'h12345678, b=32'h00000010, start pulse.
  - Required writes: addr 0..3 get 78,56,34,12; addr 4..7 get 10,00,00,00.
  - Required result: 8 reads, res=64'h0000000123456780, err=0.
  - done is high exactly 1 cycle, 41 cycles after start.
- Write ordering: slave delays wready 3 cycles after AW and bvalid 2 cycles.
  - wvalid/wdata stay stable and awvalid drops right after its handshake.
  - bready is high only in WRESP.
  - Result is still correct.
- Read backpressure: arready held low 10 cycles on beat 0.
  - arvalid stays 1 with araddr=0 throughout, with no extra reads.
  - res is correct and done is delayed exactly 10 cycles.
- Error: slave returns bresp=0 on write beat 2 and rresp=0 on read beat 5.
  - All 16 beats complete and err=1 at done.
  - The next clean transaction clears err to 0.
- start pulsed again 5 cycles into a transaction → ignored; exactly 8 writes and 8 reads occur.
- rst asserted during RADDR beat 3 → all outputs 0 asynchronously, state IDLE.
  - A following start runs a full, correct transaction from addr 0.
